// File: rtl/ps2_rx_if.sv
// ps2_rx_if - receive-side handshake between the PS/2 RX engine and the
// controller host interface. The engine is the master (drives the byte and
// status); the controller is the slave and owns rx_en.
interface ps2_rx_if;
  logic       rx_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_busy;

  modport master (
    input  rx_en,
    output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy
  );

  modport slave (
    output rx_en,
    input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy
  );
endinterface

// File: rtl/ps2_rx.sv
// ps2_rx - host-side PS/2 receive engine. Synchronizes and filters the raw
// PS/2 clock, strobes on filtered falling edges and deframes 11-bit
// device-to-host frames (start, 8 data LSB-first, odd parity, stop).
// Optional build macro PS2_RX_TIMEOUT_EN adds a watchdog that aborts a frame
// after TIMEOUT_CYCLES cycles without a falling edge.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     ps2_clk_i,
  input  logic     ps2_data_i,
  ps2_rx_if.master rx_if
);
  localparam int FW = $clog2(FILTER_LEN);

  if (FILTER_LEN < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("ps2_rx: FILTER_LEN and TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    csync_q, csync_d, dsync_q, dsync_d;
  logic          fclk_q, fclk_d, fclk_prev_q, fclk_prev_d, fall_q, fall_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d, rx_data_q, rx_data_d;
  logic          par_q, par_d, perr_q, perr_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;
  logic          clk_s, data_s;

  assign clk_s  = csync_q[1];
  assign data_s = dsync_q[1];

  // Input conditioning: 2-FF synchronizers, counter filter and fall strobe.
  // The filter counts consecutive samples that disagree with fclk and only
  // flips fclk on the FILTER_LEN-th one, so shorter glitches are absorbed.
  always_comb begin
    csync_d     = {csync_q[0], ps2_clk_i};
    dsync_d     = {dsync_q[0], ps2_data_i};
    fclk_d      = fclk_q;
    fcnt_d      = '0;
    if (clk_s != fclk_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) fclk_d = clk_s;
      else                               fcnt_d = fcnt_q + 1'b1;
    end
    fclk_prev_d = fclk_q;
    fall_d      = fclk_prev_q & ~fclk_q;
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] wd_q, wd_d;

  // Watchdog: cleared by every fall and while idle, otherwise counts up.
  always_comb begin
    if (fall_q || state_q == IDLE) wd_d = '0;
    else                           wd_d = wd_q + 1'b1;
  end

  // Watchdog register.
  always_ff @(posedge clk) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`endif

  // Deframing FSM: next state, shift register and output pulses.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    rx_data_d = rx_data_q;
    perr_d    = perr_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: if (fall_q && !data_s) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (fall_q) begin
        shreg_d   = {data_s, shreg_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall_q) begin
        par_d   = data_s;
        state_d = STOP;
      end
      STOP: if (fall_q) begin
        state_d = IDLE;
        if (data_s) begin
          rx_data_d = shreg_q;
          perr_d    = ~(^shreg_q ^ par_q);
          valid_d   = 1'b1;
        end else begin
          ferr_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PS2_RX_TIMEOUT_EN
    // A fall in the same cycle restarts the watchdog, so it wins.
    if (state_q != IDLE && !fall_q && wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end
`endif
    // Disabled receiver discards the frame silently, even in a STOP fall.
    if (!rx_if.rx_en) begin
      state_d   = IDLE;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      rx_data_d = rx_data_q;
      perr_d    = perr_q;
    end
  end

  // State register; synchronizers and filter idle high (released bus).
  always_ff @(posedge clk) begin
    if (reset) begin
      csync_q     <= 2'b11;
      dsync_q     <= 2'b11;
      fclk_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
      fcnt_q      <= '0;
      fall_q      <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      rx_data_q   <= '0;
      perr_q      <= 1'b0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      csync_q     <= csync_d;
      dsync_q     <= dsync_d;
      fclk_q      <= fclk_d;
      fclk_prev_q <= fclk_prev_d;
      fcnt_q      <= fcnt_d;
      fall_q      <= fall_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      rx_data_q   <= rx_data_d;
      perr_q      <= perr_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
    end
  end

  assign rx_if.rx_data       = rx_data_q;
  assign rx_if.rx_valid      = valid_q;
  assign rx_if.rx_parity_err = perr_q;
  assign rx_if.rx_frame_err  = ferr_q;
  assign rx_if.rx_busy       = (state_q != IDLE);
endmodule

// File: doc/ps2_rx.md
# ps2_rx

Host-side PS/2 receive engine for the PS2 controller. Samples the device-driven `ps2_clk`/`ps2_data` lines in the system clock domain and deframes 11-bit device-to-host frames: start, 8 data LSB-first, odd parity, stop. Delivers one byte per frame with parity and framing status to the controller's host interface. Sits between the PS/2 pad tri-state buffers and the controller's receive buffer; the controller's TX path drives the lines and owns `rx_en`.

## Interface

Parameters:
- `FILTER_LEN`, 8 – consecutive equal synchronized samples required before the filtered `ps2_clk` changes (≥2).
- `TIMEOUT_CYCLES`, 10000 – system cycles without a filtered falling edge before an open frame is aborted. Applies only with `PS2_RX_TIMEOUT_EN`.

Ports:
- `clk`  input  1  system clock
- `reset`  input  1  synchronous, active-high reset
- `ps2_clk_i`  input  1  raw PS/2 clock line (asynchronous)
- `ps2_data_i`  input  1  raw PS/2 data line (asynchronous)
- `rx_en`  input  1  receive enable; low forces IDLE and discards any partial frame
- `rx_data`  output  8  received byte; valid when `rx_valid`=1
- `rx_valid`  output  1  one-cycle pulse per completed frame with a good stop bit
- `rx_parity_err`  output  1  qualified by `rx_valid`; 1 when data+parity has even ones count
- `rx_frame_err`  output  1  one-cycle pulse: stop bit sampled 0, or timeout abort
- `rx_busy`  output  1  1 whenever the FSM is not IDLE

## Operation

- Clock and reset: one clock `clk`; reset is synchronous and active-high.
- Input conditioning:
  - Both lines pass a 2-FF synchronizer.
  - Synchronized clock feeds a counter filter. Filtered clock `fclk` takes the new level after `FILTER_LEN` consecutive identical samples that differ from its current value.
  - A registered `fclk` 1→0 transition produces a one-cycle `fall` strobe.
  - The synchronized data line is sampled in the `fall` cycle.
- FSM states IDLE, DATA, PARITY, STOP:
  - IDLE: `fall` with data=0 → DATA, bit count = 0. `fall` with data=1 → ignored, remain IDLE.
  - DATA: each `fall` shifts data into `shreg[7]` (shift right, so LSB ends in bit 0). After the 8th `fall` → PARITY.
  - PARITY: on `fall`, latch parity bit → STOP.
  - STOP, on `fall`:
    - data=1: `rx_data`←`shreg`; `rx_parity_err`←~(^shreg ^ parity); pulse `rx_valid` → IDLE.
    - data=0: pulse `rx_frame_err`; `rx_data` unchanged; no `rx_valid` → IDLE.
- `rx_en`=0: state → IDLE on the next edge and no pulses are generated. The synchronizers and filter keep running so edge history stays consistent.
- `rx_data` and `rx_parity_err` hold their values until the next `rx_valid`.

## Timing

- Reset values: `rx_data`=0x00; `rx_valid`, `rx_parity_err`, `rx_frame_err`, `rx_busy`=0. Synchronizer and filter outputs reset to 1 (idle bus). FSM resets to IDLE. Counters reset to 0.
- Reset mid-frame: the frame is discarded with no pulses. The next start bit after reset is received normally.
- Latency: `rx_valid` / `rx_frame_err` rise exactly `FILTER_LEN`+4 `clk` cycles after the `ps2_clk_i` pin falls for the stop bit, given a clean line.
  - Breakdown: 2 sync + `FILTER_LEN` filter + 1 edge + 1 output register.
- Data setup: `ps2_data_i` must be stable from 2 cycles before the `ps2_clk_i` fall until `FILTER_LEN`+2 cycles after it. PS/2 devices change data only while the clock is high, which satisfies this.
- `rx_busy` rises the cycle after the start-bit `fall` and clears in the same cycle `rx_valid` / `rx_frame_err` is asserted.
- Simultaneous events: `rx_en` deasserted in a STOP-state `fall` cycle → no pulse; the `rx_en` abort takes priority. `reset` overrides everything.
- Back-to-back frames need no idle gap beyond the line protocol.

## Configuration

- `PS2_RX_TIMEOUT_EN` defined:
  - A watchdog counter clears on every `fall` and in IDLE, and increments otherwise.
  - When it reaches `TIMEOUT_CYCLES`-1 in a non-IDLE state, the FSM returns to IDLE and `rx_frame_err` pulses for one cycle.
- `PS2_RX_TIMEOUT_EN` undefined: no counter is built; a partial frame waits indefinitely for more edges. `TIMEOUT_CYCLES` is ignored.

## Test plan

- Clean frame 0xA5, parity 1 → one `rx_valid`, `rx_data`=0xA5, `rx_parity_err`=0, at `FILTER_LEN`+4 cycles after the stop-bit clock fall.
- Frame 0x3C with inverted parity bit → `rx_valid`=1, `rx_data`=0x3C, `rx_parity_err`=1.
- Frame 0x81 with stop bit driven 0 → `rx_frame_err` one-cycle pulse; no `rx_valid`; `rx_data` holds the prior value.
- Glitches on idle `ps2_clk_i`:
  - A low glitch of `FILTER_LEN`-1 cycles → no `rx_busy` and no pulse.
  - A subsequent frame 0x5A → received correctly.
- With `PS2_RX_TIMEOUT_EN`: stop clocking after 4 data bits → `rx_frame_err` after `TIMEOUT_CYCLES`, `rx_busy`=0. A following frame 0xF0 is received intact.
- Aborts mid-frame (frame 0x12):
  - Pulse `rx_en` low after bit 3 → no output pulse.
  - Assert `reset` after bit 5 → all outputs at reset values.
  - In both cases the next frame 0x34 is received correctly.
